fp_int_converter: RTL and testbench



---
 rtl/fp_int_converter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_fp_int_converter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int_converter.sv
// fp_int_converter: two-stage pipelined IEEE-754 <-> integer converter.
// Both directions share one elastic datapath; the direction is chosen per transaction.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   in_valid/in_ready input handshake
//   in_mode           0 = int->fp, 1 = fp->int
//   in_signed         integer side is two's complement (1) or unsigned (0)
//   in_data           operand, LSB-aligned
//   in_rmode          rounding mode, present only with FP_CONV_RMODE_EN:
//                     00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   out_valid/out_ready output handshake
//   out_data          result, LSB-aligned, upper bits zero
//   out_flags         {NV, OF, NX}
//
// Optional macro FP_CONV_RMODE_EN adds in_rmode; without it rounding is fixed to RNE.
module fp_int_converter #(
    parameter int EXP_BITS  = 8,
    parameter int FRAC_BITS = 23,
    parameter int INT_WIDTH = 32,
    localparam int DATA_W   = ((1 + EXP_BITS + FRAC_BITS) > INT_WIDTH)
                              ? (1 + EXP_BITS + FRAC_BITS) : INT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic              in_signed,
`ifdef FP_CONV_RMODE_EN
    input  logic [1:0]        in_rmode,
`endif
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_flags
);

    localparam int E    = EXP_BITS;
    localparam int F    = FRAC_BITS;
    localparam int W    = INT_WIDTH;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int EMAX = (1 << E) - 1;
    localparam int LZW  = $clog2(W + 1);
    // Alignment width: W integer bits plus F+2 fraction bits keeps
    // every value with exponent >= -1 exact after the shift.
    localparam int AW   = W + F + 2;

    localparam logic [W-1:0] SMAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0] UMAX = '1;

    typedef struct packed {
        logic               mode;
        logic               sgn_int;
        logic [1:0]         rm;
        logic               sign;
        logic               zero;
        logic               nan;
        logic               inf;
        logic               big;
        logic signed [31:0] exp;
        logic [W-1:0]       mag;
        logic               guard;
        logic               sticky;
    } s1_t;

    function automatic logic round_up(
        input logic [1:0] rm,
        input logic       sign,
        input logic       lsb,
        input logic       g,
        input logic       s
    );
        unique case (rm)
            2'b00:   round_up = g && (s || lsb);
            2'b01:   round_up = 1'b0;
            2'b10:   round_up = sign && (g || s);
            default: round_up = !sign && (g || s);
        endcase
    endfunction

    logic [1:0] rm_in;
`ifdef FP_CONV_RMODE_EN
    assign rm_in = in_rmode;
`else
    assign rm_in = 2'b00;
`endif

    logic s1_valid;
    s1_t  s1_q;
    s1_t  s1_d;
    logic s2_ready;
    logic s1_adv;

    assign s2_ready = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_ready;
    assign in_ready = rst_n && (!s1_valid || s1_adv);

    // ---------------- S1: unpack, magnitude, LZC, align ----------------
    logic [W-1:0]       ival;
    logic               ineg;
    logic [W-1:0]       imag;
    logic [LZW-1:0]     lz;
    logic               fsign;
    logic [E-1:0]       fexp;
    logic [F-1:0]       ffrac;
    logic [F:0]         fman;
    logic signed [31:0] fe;
    logic [31:0]        sh;
    logic [AW-1:0]      fvec;

    always_comb begin
        s1_d    = '0;
        ival    = in_data[W-1:0];
        ineg    = in_signed && ival[W-1];
        imag    = ineg ? -ival : ival;
        lz      = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (imag[i]) lz = LZW'(W - 1 - i);
        end
        fsign   = in_data[E+F];
        fexp    = in_data[E+F-1:F];
        ffrac   = in_data[F-1:0];
        fman    = {|fexp, ffrac};
        fe      = (fexp == '0) ? 32'(1 - BIAS)
                               : 32'(fexp) - 32'(BIAS);
        sh      = (fe >= -1 && fe <= W - 1) ? 32'(fe + 2) : 32'd0;
        fvec    = AW'(fman) << sh;

        s1_d.mode    = in_mode;
        s1_d.sgn_int = in_signed;
        s1_d.rm      = rm_in;
        if (in_mode) begin
            s1_d.sign = fsign;
            s1_d.nan  = (&fexp) && (|ffrac);
            s1_d.inf  = (&fexp) && !(|ffrac);
            s1_d.big  = !(&fexp) && (fe > W - 1);
            if (fe < -1) begin
                // |x| < 0.5: only stickiness survives
                s1_d.sticky = |fman;
            end else begin
                s1_d.mag    = fvec[AW-1 -: W];
                s1_d.guard  = fvec[F+1];
                s1_d.sticky = |fvec[F:0];
            end
        end else begin
            s1_d.sign = ineg;
            s1_d.zero = (imag == '0);
            s1_d.mag  = imag << lz;
            s1_d.exp  = 32'(W - 1) - 32'(lz);
        end
    end

    // ---------------- S2: round, exponent adjust, pack, flags ----------------
    logic [AW-1:0]      ext;
    logic [F:0]         mant;
    logic               i_g;
    logic               i_s;
    logic               i_up;
    logic [F+1:0]       mr;
    logic signed [31:0] be;
    logic               f_up;
    logic [W:0]         r;
    logic               f_nx;
    logic               sat_fin;
    logic [E+F:0]       res_f;
    logic [W-1:0]       res_i;
    logic               nv;
    logic               of;
    logic               nx;

    always_comb begin
        ext     = {s1_q.mag, {(F + 2){1'b0}}};
        mant    = ext[AW-1 -: F+1];
        i_g     = ext[AW-F-2];
        i_s     = |ext[AW-F-3:0];
        i_up    = round_up(s1_q.rm, s1_q.sign, mant[0], i_g, i_s);
        mr      = {1'b0, mant} + (F + 2)'(i_up);
        be      = s1_q.exp + BIAS + 32'(mr[F+1]);
        f_up    = round_up(s1_q.rm, s1_q.sign, s1_q.mag[0],
                           s1_q.guard, s1_q.sticky);
        r       = {1'b0, s1_q.mag} + (W + 1)'(f_up);
        f_nx    = s1_q.guard | s1_q.sticky;
        // Directed modes that never round away from zero saturate finite
        sat_fin = (s1_q.rm == 2'b01)
               || (s1_q.rm == 2'b10 && !s1_q.sign)
               || (s1_q.rm == 2'b11 && s1_q.sign);
        res_f   = '0;
        res_i   = '0;
        nv      = 1'b0;
        of      = 1'b0;
        nx      = 1'b0;

        if (!s1_q.mode) begin
            if (!s1_q.zero) begin
                if (be >= EMAX) begin
                    of = 1'b1;
                    nx = 1'b1;
                    res_f = sat_fin
                          ? {s1_q.sign, E'(EMAX - 1), {F{1'b1}}}
                          : {s1_q.sign, {E{1'b1}}, {F{1'b0}}};
                end else begin
                    nx = i_g | i_s;
                    res_f = {s1_q.sign, be[E-1:0],
                             mr[F+1] ? mr[F:1] : mr[F-1:0]};
                end
            end
        end else if (s1_q.nan) begin
            nv = 1'b1;
            res_i = s1_q.sgn_int ? SMAX : UMAX;
        end else if (s1_q.inf || s1_q.big) begin
            nv = 1'b1;
            res_i = s1_q.sign ? (s1_q.sgn_int ? SMIN : '0)
                              : (s1_q.sgn_int ? SMAX : UMAX);
        end else if (s1_q.sgn_int) begin
            if (!s1_q.sign) begin
                if (r[W] || r[W-1]) begin
                    nv = 1'b1;
                    res_i = SMAX;
                end else begin
                    nx = f_nx;
                    res_i = r[W-1:0];
                end
            end else if (r[W] || (r[W-1] && (|r[W-2:0]))) begin
                nv = 1'b1;
                res_i = SMIN;
            end else begin
                nx = f_nx;
                res_i = -r[W-1:0];
            end
        end else begin
            if (!s1_q.sign) begin
                if (r[W]) begin
                    nv = 1'b1;
                    res_i = UMAX;
                end else begin
                    nx = f_nx;
                    res_i = r[W-1:0];
                end
            end else if (r != '0) begin
                nv = 1'b1;
            end else begin
                nx = f_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data  <= s1_q.mode ? DATA_W'(res_i) : DATA_W'(res_f);
                    out_flags <= {nv, of, nx};
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_int_converter.sv
// tb_fp_int_converter: directed and random checks of fp_int_converter
// (EXP_BITS=8, FRAC_BITS=23, INT_WIDTH=32) against an arithmetic model.
module tb_fp_int_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic        in_signed;
    logic [1:0]  in_rmode;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    logic done;

    logic [34:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [34:0] hold;

    fp_int_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_signed(in_signed),
`ifdef FP_CONV_RMODE_EN
        .in_rmode (in_rmode),
`endif
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_flags(out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    function automatic logic rnd(input logic [1:0] rm, input logic neg,
                                 input logic gt, input logic eq,
                                 input logic odd, input logic inexact);
        case (rm)
            2'd0:    return gt || (eq && odd);
            2'd1:    return 1'b0;
            2'd2:    return neg && inexact;
            default: return !neg && inexact;
        endcase
    endfunction

    // Integer -> binary32 by exact integer division into ulps.
    function automatic logic [34:0] mdl_i2f(input logic sgn,
                                            input logic [1:0] rm,
                                            input logic [31:0] d);
        longint v, mag, q, rem, half;
        int e, sh;
        logic neg, up;
        v = sgn ? longint'($signed(d)) : longint'({32'd0, d});
        if (v == 0) return 35'd0;
        neg = v < 0;
        mag = neg ? -v : v;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = mag << (23 - e);
            rem = 0;
            half = 1;
        end else begin
            sh = e - 23;
            q = mag >> sh;
            rem = mag - (q << sh);
            half = longint'(1) << (sh - 1);
        end
        up = rnd(rm, neg, rem > half, rem == half, q[0], rem != 0);
        q = q + longint'(up);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        return {2'b00, rem != 0, neg, 8'(e + 127), q[22:0]};
    endfunction

    // binary32 -> integer: value = m * 2^(e-23), rounded, range-checked.
    function automatic logic [34:0] mdl_f2i(input logic sgn,
                                            input logic [1:0] rm,
                                            input logic [31:0] d);
        longint m, q, rem, half, r, val, lo, hi;
        int ex, e, sh;
        logic neg, up;
        neg = d[31];
        ex = int'(d[30:23]);
        lo = sgn ? -(longint'(1) << 31) : 0;
        hi = sgn ? (longint'(1) << 31) - 1 : (longint'(1) << 32) - 1;
        if (ex == 255) begin
            if (d[22:0] != 0)
                return {3'b100, sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF};
            return {3'b100, neg ? 32'(lo) : 32'(hi)};
        end
        m = longint'(d[22:0]);
        if (ex != 0) m = m + (longint'(1) << 23);
        e = (ex == 0) ? -126 : ex - 127;
        if (e > 40) return {3'b100, neg ? 32'(lo) : 32'(hi)};
        if (e >= 23) begin
            q = m << (e - 23);
            rem = 0;
            half = 1;
        end else begin
            sh = 23 - e;
            if (sh > 40) begin
                q = 0;
                rem = m;
                half = longint'(1) << 40;
            end else begin
                q = m >> sh;
                rem = m - (q << sh);
                half = longint'(1) << (sh - 1);
            end
        end
        up = rnd(rm, neg, rem > half, rem == half, q[0], rem != 0);
        r = q + longint'(up);
        val = neg ? -r : r;
        if (val < lo || val > hi)
            return {3'b100, neg ? 32'(lo) : 32'(hi)};
        return {2'b00, rem != 0, 32'(val)};
    endfunction

    function automatic logic [34:0] mdl(input logic m, input logic s,
                                        input logic [1:0] rm,
                                        input logic [31:0] d);
        return m ? mdl_f2i(s, rm, d) : mdl_i2f(s, rm, d);
    endfunction

    // Scoreboard: push on accepted input, pop on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_hold_valid", 64'(out_valid), 64'd1);
                chk("stall_hold_data", 64'({out_flags, out_data}),
                    64'(hold));
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_output");
                end else begin
                    chk("result", 64'({out_flags, out_data}),
                        64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                exp_q.push_back(mdl(in_mode, in_signed, in_rmode, in_data));
            end
            stalled = out_valid && !out_ready;
            hold = {out_flags, out_data};
        end
    end

    task automatic send(input logic m, input logic s, input logic [1:0] rm,
                        input logic [31:0] d);
        int budget = 50;
        in_valid = 1'b1;
        in_mode = m;
        in_signed = s;
        in_rmode = rm;
        in_data = d;
        while (!in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!in_ready) timeout_fail("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic dvec(input string nm, input logic m, input logic s,
                        input logic [1:0] rm, input logic [31:0] d,
                        input logic [34:0] req);
        chk(nm, 64'(mdl(m, s, rm, d)), 64'(req));
        send(m, s, rm, d);
    endtask

    task automatic drain(input string nm);
        int budget = 200;
        while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) timeout_fail(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, o0, budget;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_signed = 1'b0;
        in_rmode = 2'b00;
        in_data = '0;
        out_ready = 1'b1;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Latency: accept, then out_valid follows one edge later.
        chk("m_i2f_m1", 64'(mdl(0, 1, 0, 32'hFFFF_FFFF)),
            64'({3'b000, 32'hBF80_0000}));
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_signed = 1'b1;
        in_data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        drain("drain_lat");

        dvec("m_u_tie", 0, 0, 0, 32'h0100_0001, {3'b001, 32'h4B80_0000});
        dvec("m_u_up", 0, 0, 0, 32'h0100_0003, {3'b001, 32'h4B80_0002});
        dvec("m_zero", 0, 1, 0, 32'h0000_0000, {3'b000, 32'h0000_0000});
        dvec("m_smin", 0, 1, 0, 32'h8000_0000, {3'b000, 32'hCF00_0000});
        dvec("m_umax", 0, 0, 0, 32'hFFFF_FFFF, {3'b001, 32'h4F80_0000});
        dvec("m_2p31", 1, 1, 0, 32'h4F00_0000, {3'b100, 32'h7FFF_FFFF});
        dvec("m_m2p31", 1, 1, 0, 32'hCF00_0000, {3'b000, 32'h8000_0000});
        dvec("m_1p5", 1, 1, 0, 32'h3FC0_0000, {3'b001, 32'h0000_0002});
        dvec("m_2p5", 1, 1, 0, 32'h4020_0000, {3'b001, 32'h0000_0002});
        dvec("m_nan", 1, 1, 0, 32'h7FC0_0000, {3'b100, 32'h7FFF_FFFF});
        dvec("m_u_m1", 1, 0, 0, 32'hBF80_0000, {3'b100, 32'h0000_0000});
        dvec("m_u_mhalf", 1, 0, 0, 32'hBF00_0000, {3'b001, 32'h0000_0000});
        dvec("m_u_2p32", 1, 0, 0, 32'h4F80_0000, {3'b100, 32'hFFFF_FFFF});
        dvec("m_ninf", 1, 1, 0, 32'hFF80_0000, {3'b100, 32'h8000_0000});
        dvec("m_subn", 1, 1, 0, 32'h0000_0001, {3'b001, 32'h0000_0000});
        dvec("m_half_up", 1, 1, 0, 32'h3F00_0001, {3'b001, 32'h0000_0001});
        dvec("m_u_nan", 1, 0, 0, 32'hFFC0_0000, {3'b100, 32'hFFFF_FFFF});
`ifdef FP_CONV_RMODE_EN
        dvec("m_rtz_1p5", 1, 1, 2'b01, 32'h3FC0_0000,
             {3'b001, 32'h0000_0001});
        dvec("m_rdn_m1p5", 1, 1, 2'b10, 32'hBFC0_0000,
             {3'b001, 32'hFFFF_FFFE});
        dvec("m_rup_i2f", 0, 0, 2'b11, 32'h0100_0001,
             {3'b001, 32'h4B80_0001});
`endif
        drain("drain_directed");

        // Back-to-back with a 5-cycle output stall.
        a0 = acc_cnt;
        o0 = out_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(0, 1, 0, 32'(i * 3 - 4));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_accepted", 64'(acc_cnt - a0), 64'd2);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                chk("stall_rate", 64'(out_cnt - o0), 64'd4);
            end
        join
        drain("drain_stall");

        // Reset with both stages full.
        out_ready = 1'b0;
        send(1, 1, 0, 32'h3F80_0000);
        send(1, 1, 0, 32'h4000_0000);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("full_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("full_rst_out_valid", 64'(out_valid), 64'd0);
        chk("full_rst_out_data", 64'(out_data), 64'd0);
        chk("full_rst_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("full_rel_in_ready", 64'(in_ready), 64'd1);
        send(1, 1, 0, 32'h3FC0_0000);
        budget = 20;
        while (!out_valid && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!out_valid) timeout_fail("post_reset_wait");
        else chk("post_reset_result", 64'({out_flags, out_data}),
                 64'({3'b001, 32'h0000_0002}));
        drain("drain_reset");

        // Random traffic with random backpressure.
        fork
            begin
                logic [31:0] d;
                logic m;
                for (int i = 0; i < 300; i++) begin
                    m = 1'($urandom_range(0, 1));
                    d = $urandom;
                    if (m && $urandom_range(0, 3) != 0)
                        d[30:23] = 8'($urandom_range(100, 162));
                    else if (!m && $urandom_range(0, 1) != 0)
                        d = d >> $urandom_range(0, 31);
`ifdef FP_CONV_RMODE_EN
                    send(m, 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), d);
`else
                    send(m, 1'($urandom_range(0, 1)), 2'b00, d);
`endif
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
